// File: rtl/cla_limb_sequencer_if.sv
// cla_limb_sequencer_if
// Bundles the signals around the limb sequencer: the operand input stream,
// the sum output stream, the adder-side connections and the busy flag.
//   slave  : the sequencer itself (accepts operand beats, drives the adder
//            inputs, produces sum limbs)
//   master : the surroundings (input demux, carry_look_ahead, downstream sink)
// Parameter WIDTH must match the sequencer and adder limb width.
interface cla_limb_sequencer_if #(
    parameter int WIDTH = 7
);
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_ready;
    logic             op_sub;

    logic [WIDTH-1:0] cla_a;
    logic [WIDTH-1:0] cla_b;
    logic             cla_y;
    logic [WIDTH-1:0] cla_s;
    logic             cla_c;

    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_last;
    logic             out_carry;
    logic             out_ready;

    logic             busy;

    modport slave (
        input  in_valid, in_data, op_sub, cla_s, cla_c, out_ready,
        output in_ready, cla_a, cla_b, cla_y,
        output out_valid, out_data, out_last, out_carry, busy
    );

    modport master (
        output in_valid, in_data, op_sub, cla_s, cla_c, out_ready,
        input  in_ready, cla_a, cla_b, cla_y,
        input  out_valid, out_data, out_last, out_carry, busy
    );
endinterface

// File: rtl/cla_limb_sequencer.sv
// cla_limb_sequencer
// Sequences a multi-limb add (or subtract) through a single WIDTH-bit
// combinational carry look-ahead adder. Operand limbs arrive LSB limb first,
// A beat then B beat; the carry is chained limb to limb and each sum limb is
// emitted on a valid/ready stream.
//
// Ports:
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset
//   bus    : cla_limb_sequencer_if.slave
//            in_valid/in_data/in_ready/op_sub  operand stream
//            cla_a/cla_b/cla_y -> adder, cla_s/cla_c <- adder
//            out_valid/out_data/out_last/out_carry/out_ready  sum stream
//            busy  operation in progress
//
// Build option: define CLA_SEQ_SUB_EN to implement subtract mode (B inverted,
// initial carry 1). Without it op_sub is ignored and every operation is an add.
//
// State  | meaning
// S_A    | waiting for the A limb (in_ready high)
// S_B    | waiting for the B limb (in_ready high)
// S_EXEC | adder settling for one cycle; sum and carry captured at its end
// S_OUT  | sum limb presented, held until out_ready
module cla_limb_sequencer #(
    parameter int WIDTH = 7,
    parameter int LIMBS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    cla_limb_sequencer_if.slave   bus
);

    typedef enum logic [1:0] {
        S_A    = 2'd0,
        S_B    = 2'd1,
        S_EXEC = 2'd2,
        S_OUT  = 2'd3
    } state_t;

    localparam logic [3:0] LAST_IDX = 4'(LIMBS - 1);

    state_t           state;
    logic [3:0]       idx;
    logic [WIDTH-1:0] cla_a_q;
    logic [WIDTH-1:0] cla_b_q;
    logic             carry_q;
    logic [WIDTH-1:0] out_data_q;
    logic             out_last_q;
    logic             out_carry_q;
`ifdef CLA_SEQ_SUB_EN
    logic             sub_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_A;
            idx         <= '0;
            cla_a_q     <= '0;
            cla_b_q     <= '0;
            carry_q     <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            out_carry_q <= 1'b0;
`ifdef CLA_SEQ_SUB_EN
            sub_q       <= 1'b0;
`endif
        end else begin
            case (state)
                S_A: begin
                    if (bus.in_valid) begin
                        cla_a_q <= bus.in_data;
                        // Mode and initial carry belong to the whole operation,
                        // so they are only taken on the first limb.
                        if (idx == 4'd0) begin
`ifdef CLA_SEQ_SUB_EN
                            sub_q   <= bus.op_sub;
                            carry_q <= bus.op_sub;
`else
                            carry_q <= 1'b0;
`endif
                        end
                        state <= S_B;
                    end
                end
                S_B: begin
                    if (bus.in_valid) begin
`ifdef CLA_SEQ_SUB_EN
                        cla_b_q <= sub_q ? ~bus.in_data : bus.in_data;
`else
                        cla_b_q <= bus.in_data;
`endif
                        state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    out_data_q  <= bus.cla_s;
                    carry_q     <= bus.cla_c;
                    out_carry_q <= bus.cla_c;
                    out_last_q  <= (idx == LAST_IDX);
                    state       <= S_OUT;
                end
                S_OUT: begin
                    if (bus.out_ready) begin
                        idx   <= out_last_q ? 4'd0 : idx + 4'd1;
                        state <= S_A;
                    end
                end
                default: state <= S_A;
            endcase
        end
    end

    // Handshake flags decode straight from state: no path from in_valid or
    // out_ready, which is also why a new A beat cannot share the output
    // handshake cycle.
    assign bus.in_ready  = (state == S_A) || (state == S_B);
    assign bus.out_valid = (state == S_OUT);
    assign bus.busy      = (idx != 4'd0) || (state != S_A);

    assign bus.cla_a     = cla_a_q;
    assign bus.cla_b     = cla_b_q;
    assign bus.cla_y     = carry_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_last  = out_last_q;
    assign bus.out_carry = out_carry_q;

endmodule
